ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_pkg.sv | 21 ++
 rtl/ccff_bit_counter.sv | 33 +++
 rtl/ccff_loader.sv | 129 ++++++++++++
 tb/tb_ccff_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain loader.
// This package holds the FSM state encoding and the byte width used by the loader and its counter.
package ccff_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    RB,
    FIN
  } ccff_state_t;

  // The low nbits of v hold the valid bits. They are moved to the top of the byte, and the vacated bits are zero.
  function automatic logic [BYTE_W-1:0] left_justify(input logic [BYTE_W-1:0] v,
                                                     input int nbits);
    return (nbits >= BYTE_W) ? v : (v << (BYTE_W - nbits));
  endfunction

endpackage

// File: rtl/ccff_bit_counter.sv
// Counts the chain bits moved during a load or a readback.
// It flags the end of each byte and the final bit of the chain.
module ccff_bit_counter
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 256,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic byte_last,
  output logic tc_hit
);

  logic [CNT_W-1:0] bit_cnt;
  logic             at_term;

  assign at_term   = (bit_cnt == CNT_W'(CHAIN_LEN));
  assign tc_hit    = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign byte_last = (bit_cnt[2:0] == 3'(BYTE_W - 1));

  // The counter saturates at CHAIN_LEN, so a stray increment can never wrap it.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      bit_cnt <= '0;
    end else if (inc && !at_term) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// This module serially loads the fabric configuration chain from a byte stream.
// It also performs a non-destructive readback by recirculating the chain.
module ccff_loader #(
  parameter int CHAIN_LEN = 256,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_start,
  input  logic       rb_start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       ccff_head,
  input  logic       ccff_tail,
  output logic       shift_en,
  output logic [7:0] rb_byte,
  output logic       rb_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] xsum
);

  import ccff_pkg::*;

  localparam int TAIL_BITS = CHAIN_LEN % BYTE_W;

  ccff_state_t       state;
  logic [BYTE_W-1:0] sr;
  logic [BYTE_W-1:0] rb_sr;
  logic [BYTE_W-1:0] rb_next;
  logic              idle_like;
  logic              cnt_clear;
  logic              cnt_inc;
  logic              byte_last;
  logic              tc_hit;

  assign idle_like = (state == IDLE) || (state == FIN);
  assign cnt_clear = idle_like && (load_start || rb_start);
  assign cnt_inc   = (state == SHIFT) || (state == RB);
  assign rb_next   = {rb_sr[BYTE_W-2:0], ccff_tail};

  // During readback the head must follow the tail in the same cycle. For this reason, the chain controls are decoded from the state rather than stored in registers.
  assign shift_en  = cnt_inc;
  assign ccff_head = (state == SHIFT) ? sr[BYTE_W-1] :
                     (state == RB)    ? ccff_tail    : 1'b0;

  ccff_bit_counter #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_bit_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .inc       (cnt_inc),
    .byte_last (byte_last),
    .tc_hit    (tc_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      rb_sr      <= '0;
      xsum       <= '0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rb_valid   <= 1'b0;
      rb_byte    <= '0;
    end else begin
      rb_valid <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (load_start) begin
            xsum       <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            byte_ready <= 1'b1;
            state      <= FETCH;
          end else if (rb_start) begin
            rb_sr <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= RB;
          end
        end
        FETCH: begin
          if (byte_valid && byte_ready) begin
            sr         <= byte_in;
            xsum       <= xsum ^ byte_in;
            byte_ready <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          sr <= {sr[BYTE_W-2:0], 1'b0};
          if (tc_hit) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else if (byte_last) begin
            byte_ready <= 1'b1;
            state      <= FETCH;
          end
        end
        RB: begin
          rb_sr <= rb_next;
          if (byte_last) begin
            rb_valid <= 1'b1;
            rb_byte  <= rb_next;
          end
          // A chain length that is not a multiple of 8 leaves a short final byte. That byte is still delivered.
          if (tc_hit) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
            if (TAIL_BITS != 0) begin
              rb_valid <= 1'b1;
              rb_byte  <= left_justify(rb_next, TAIL_BITS);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench for ccff_loader. It drives a 16-bit chain and a 12-bit chain in lock step.
// Each chain has a behavioural fabric model that feeds ccff_tail.
module tb_ccff_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start;
  logic       rb_start;
  logic       byte_valid;
  logic [7:0] byte_in;

  logic [1:0] byte_ready;
  logic [1:0] ccff_head;
  logic [1:0] ccff_tail;
  logic [1:0] shift_en;
  logic [1:0] rb_valid;
  logic [1:0] busy;
  logic [1:0] done;
  logic [7:0] rb_byte [2];
  logic [7:0] xsum [2];

  logic [15:0] chain0 = '0;
  logic [11:0] chain1 = '0;

  int checks = 0;
  int errors = 0;
  bit in_rb  = 1'b0;

  logic       exp_head [2][$];
  logic [7:0] exp_rb   [2][$];
  logic [7:0] exp_xsum [2][$];
  logic [15:0] last_stream = '0;

  always #5 clk = ~clk;

  ccff_loader #(.CHAIN_LEN(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .rb_start(rb_start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready[0]),
    .ccff_head(ccff_head[0]), .ccff_tail(ccff_tail[0]), .shift_en(shift_en[0]),
    .rb_byte(rb_byte[0]), .rb_valid(rb_valid[0]), .busy(busy[0]), .done(done[0]),
    .xsum(xsum[0])
  );

  ccff_loader #(.CHAIN_LEN(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .rb_start(rb_start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready[1]),
    .ccff_head(ccff_head[1]), .ccff_tail(ccff_tail[1]), .shift_en(shift_en[1]),
    .rb_byte(rb_byte[1]), .rb_valid(rb_valid[1]), .busy(busy[1]), .done(done[1]),
    .xsum(xsum[1])
  );

  // Each fabric chain advances only on shift_en, and it keeps its contents through reset.
  always @(posedge clk) if (shift_en[0]) chain0 <= {chain0[14:0], ccff_head[0]};
  always @(posedge clk) if (shift_en[1]) chain1 <= {chain1[10:0], ccff_head[1]};
  assign ccff_tail = {chain1[11], chain0[15]};

  function automatic int clen(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  task automatic check_output(input string name, input int d, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic run_monitor();
    logic prev_rst = 1'b1;
    logic prev_done [2] = '{1'b0, 1'b0};
    int   shift_count [2] = '{0, 0};
    logic       h;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n && !prev_rst) begin
          check_output("reset_flags", d, int'({byte_ready[d], shift_en[d], ccff_head[d],
                                              busy[d], done[d], rb_valid[d]}), 0);
          check_output("reset_bytes", d, int'({rb_byte[d], xsum[d]}), 0);
        end else begin
          if (!done[d] && prev_done[d]) shift_count[d] = 0;
          if (shift_en[d]) begin
            shift_count[d]++;
            check_output("busy_while_shifting", d, int'(busy[d]), 1);
            check_output("ready_while_shifting", d, int'(byte_ready[d]), 0);
            if (in_rb) begin
              check_output("recirculate", d, int'(ccff_head[d]), int'(ccff_tail[d]));
            end else begin
              check_output("head_expected", d, int'(exp_head[d].size() != 0), 1);
              if (exp_head[d].size() != 0) begin
                h = exp_head[d].pop_front();
                check_output("head_bit", d, int'(ccff_head[d]), int'(h));
              end
            end
          end else begin
            check_output("head_idle_zero", d, int'(ccff_head[d]), 0);
          end
          if (byte_ready[d]) check_output("busy_in_fetch", d, int'(busy[d]), 1);
          if (done[d]) check_output("quiet_after_done", d, int'({busy[d], byte_ready[d]}), 0);
          if (rb_valid[d]) begin
            check_output("rb_expected", d, int'(exp_rb[d].size() != 0), 1);
            if (exp_rb[d].size() != 0) begin
              e = exp_rb[d].pop_front();
              check_output("rb_byte", d, int'(rb_byte[d]), int'(e));
            end
          end
          if (done[d] && !prev_done[d]) begin
            check_output("shift_count", d, shift_count[d], clen(d));
            if (!in_rb) begin
              check_output("xsum_expected", d, int'(exp_xsum[d].size() != 0), 1);
              if (exp_xsum[d].size() != 0) begin
                e = exp_xsum[d].pop_front();
                check_output("xsum", d, int'(xsum[d]), int'(e));
              end
              check_output("head_bits_left", d, exp_head[d].size(), 0);
            end
          end
        end
        if (!rst_n) shift_count[d] = 0;
        prev_done[d] = done[d];
      end
      prev_rst = rst_n;
    end
  endtask

  task automatic wait_done();
    int c = 0;
    while (!(done[0] && done[1]) && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    check_output("done_timeout", 0, int'(done[0] && done[1]), 1);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int c = 0;
    byte_valid = 1'b1;
    byte_in    = b;
    while (!byte_ready[0] && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check_output("ready_timeout", 0, int'(byte_ready[0]), 1);
    if (byte_ready[0]) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  // The model reads the first CHAIN_LEN bits of the byte stream, taking each byte MSB first.
  task automatic push_load(input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] stream;
    stream = {b0, b1};
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < clen(d); i++) exp_head[d].push_back(stream[15 - i]);
      exp_xsum[d].push_back(b0 ^ b1);
    end
  endtask

  task automatic do_load(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                         input bit rb_mid, input bit both_starts);
    int c = 0;
    push_load(b0, b1);
    last_stream = {b0, b1};
    load_start = 1'b1;
    rb_start   = both_starts;
    @(posedge clk); #1;
    load_start = 1'b0;
    rb_start   = 1'b0;
    send_byte(b0);
    if (rb_mid) begin
      rb_start = 1'b1;
      @(posedge clk); #1;
      rb_start = 1'b0;
    end
    if (gap > 0) begin
      while (!byte_ready[0] && c < 50) begin
        @(posedge clk); #1;
        c++;
      end
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    send_byte(b1);
    wait_done();
  endtask

  // The readback returns the loaded bits in their original order, 8 bits to a byte. A short final byte is left-justified.
  task automatic do_readback();
    int         nb;
    logic [7:0] v;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < clen(d); k += 8) begin
        nb = (clen(d) - k < 8) ? clen(d) - k : 8;
        v  = last_stream[15 - k -: 8];
        v  = v & (8'hFF << (8 - nb));
        exp_rb[d].push_back(v);
      end
    end
    in_rb    = 1'b1;
    rb_start = 1'b1;
    @(posedge clk); #1;
    rb_start = 1'b0;
    wait_done();
    in_rb = 1'b0;
  endtask

  task automatic apply_stimulus();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(8'hA5, 8'h3C, 0, 1'b0, 1'b0);
    do_readback();
    do_readback();
    do_load(8'hFF, 8'hF0, 0, 1'b0, 1'b0);
    do_readback();
    do_load(8'h5A, 8'hE1, 5, 1'b0, 1'b0);
    do_load(8'hC6, 8'h39, 0, 1'b1, 1'b1);
    do_readback();

    // This step aborts a load with reset five bits into the first byte.
    push_load(8'h3D, 8'h82);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    send_byte(8'h3D);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      exp_head[d].delete();
      exp_xsum[d].delete();
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_load(8'h96, 8'h0F, 0, 1'b0, 1'b0);
    do_readback();

    for (int n = 0; n < 16; n++) begin
      do_load(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) do_readback();
    end
    do_readback();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    rb_start   = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    $display("[TB] starting ccff_loader bench");
    fork
      run_monitor();
      apply_stimulus();
    join_any
    disable fork;
    for (int d = 0; d < 2; d++) begin
      check_output("leftover_head", d, exp_head[d].size(), 0);
      check_output("leftover_rb", d, exp_rb[d].size(), 0);
      check_output("leftover_xsum", d, exp_xsum[d].size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
